// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions for the id_stage slice: opcodes, funct codes,
// instruction formats and the immediate/legality helpers.
package id_stage_pkg;

  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;
  localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S   = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  function automatic fmt_e fmt_decode(input logic [6:0] opcode);
    fmt_e fmt;
    case (opcode)
      INST_TYPE_R_M:                        fmt = FMT_R;
      INST_TYPE_I, INST_TYPE_L, INST_JALR:  fmt = FMT_I;
      INST_TYPE_S:                          fmt = FMT_S;
      INST_TYPE_B:                          fmt = FMT_B;
      INST_LUI, INST_AUIPC:                 fmt = FMT_U;
      INST_JAL:                             fmt = FMT_J;
      default:                              fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic [31:0] imm_decode(input logic [31:0] inst, input fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'h000};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // Only opcode, the OP funct7 and reserved funct3 encodings are screened here.
  function automatic logic is_legal(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = inst[14:12];
    f7 = inst[31:25];
    case (inst[6:0])
      INST_TYPE_R_M:                               ok = (f7 == F7_BASE) || (f7 == F7_ALT);
      INST_TYPE_I, INST_LUI, INST_AUIPC, INST_JAL: ok = 1'b1;
      INST_JALR:   ok = (f3 == F3_JALR);
      INST_TYPE_B: ok = f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
      INST_TYPE_L: ok = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      INST_TYPE_S: ok = f3 inside {F3_SB, F3_SH, F3_SW};
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_fwd_unit.sv
// Operand bypass mux and hazard detect for one source register of id_stage.
module id_fwd_unit
  import id_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_wen_i,
  input  logic              ex_is_load_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_wen_i,
  input  logic [XLEN-1:0]   mem_data_i,
  output logic [XLEN-1:0]   data_o,
  output logic              stall_o
);

  localparam logic FWD = (FWD_EN != 0);

  logic nz_s;
  logic ex_hit_s;
  logic mem_hit_s;

  // rs_addr_i is already zero when the register is not read, so x0 disables both paths.
  always_comb begin
    nz_s      = (rs_addr_i != {REG_AW{1'b0}});
    ex_hit_s  = ex_wen_i && (ex_rd_i == rs_addr_i) && nz_s;
    mem_hit_s = mem_wen_i && (mem_rd_i == rs_addr_i) && nz_s;

    if (FWD && ex_hit_s && !ex_is_load_i) begin
      data_o = ex_data_i;
    end else if (FWD && mem_hit_s) begin
      data_o = mem_data_i;
    end else begin
      data_o = rf_data_i;
    end

    if (ex_hit_s && ex_is_load_i) begin
      stall_o = 1'b1;
    end else if (!FWD && (ex_hit_s || mem_hit_s)) begin
      stall_o = 1'b1;
    end else begin
      stall_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: decode, operand bypass, load-use stall and a
// valid/ready output register that feeds ex directly.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_wen_i,
  input  logic              ex_is_load_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_wen_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen_o,
  output logic              illegal_o
);

  logic [6:0]        opcode_s;
  fmt_e              fmt_s;
  logic [31:0]       imm32_s;
  logic [XLEN-1:0]   imm_s;
  logic              rs1_used_s;
  logic              rs2_used_s;
  logic [REG_AW-1:0] rs1_s;
  logic [REG_AW-1:0] rs2_s;
  logic [REG_AW-1:0] rd_s;
  logic [XLEN-1:0]   rs1_val_s;
  logic [XLEN-1:0]   rs2_val_s;
  logic [XLEN-1:0]   op1_s;
  logic [XLEN-1:0]   op2_s;
  logic              wen_base_s;
  logic              wen_s;
  logic              illegal_s;
  logic              stall1_s;
  logic              stall2_s;
  logic              stall_s;
  logic              adv_s;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       inst_q,      inst_d;
  logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
  logic [XLEN-1:0]   op1_q,       op1_d;
  logic [XLEN-1:0]   op2_q,       op2_d;
  logic [XLEN-1:0]   imm_q,       imm_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic              wen_q,       wen_d;
  logic              illegal_q,   illegal_d;

  // Field extraction, immediate and register-use decode.
  always_comb begin
    opcode_s   = inst_i[6:0];
    fmt_s      = fmt_decode(opcode_s);
    imm32_s    = imm_decode(inst_i, fmt_s);
    imm_s      = XLEN'($signed(imm32_s));
    rs1_used_s = fmt_s inside {FMT_R, FMT_I, FMT_S, FMT_B};
    rs2_used_s = fmt_s inside {FMT_R, FMT_S, FMT_B};
    rs1_s      = rs1_used_s ? REG_AW'(inst_i[19:15]) : {REG_AW{1'b0}};
    rs2_s      = rs2_used_s ? REG_AW'(inst_i[24:20]) : {REG_AW{1'b0}};
    rd_s       = REG_AW'(inst_i[11:7]);
    illegal_s  = !is_legal(inst_i);
  end

  assign rs1_addr_o = rs1_s;
  assign rs2_addr_o = rs2_s;

  id_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .rs_addr_i    (rs1_s),
    .rf_data_i    (rs1_data_i),
    .ex_rd_i      (ex_rd_i),
    .ex_wen_i     (ex_wen_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_data_i    (ex_data_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wen_i    (mem_wen_i),
    .mem_data_i   (mem_data_i),
    .data_o       (rs1_val_s),
    .stall_o      (stall1_s)
  );

  id_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .rs_addr_i    (rs2_s),
    .rf_data_i    (rs2_data_i),
    .ex_rd_i      (ex_rd_i),
    .ex_wen_i     (ex_wen_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_data_i    (ex_data_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wen_i    (mem_wen_i),
    .mem_data_i   (mem_data_i),
    .data_o       (rs2_val_s),
    .stall_o      (stall2_s)
  );

  // Operand routing and write-enable by opcode.
  always_comb begin
    case (opcode_s)
      INST_TYPE_R_M, INST_TYPE_B, INST_TYPE_S: begin
        op1_s = rs1_val_s;
        op2_s = rs2_val_s;
      end
      INST_TYPE_I, INST_TYPE_L, INST_JALR: begin
        op1_s = rs1_val_s;
        op2_s = imm_s;
      end
      INST_LUI: begin
        op1_s = imm_s;
        op2_s = {XLEN{1'b0}};
      end
      INST_AUIPC, INST_JAL: begin
        op1_s = inst_addr_i;
        op2_s = imm_s;
      end
      default: begin
        op1_s = {XLEN{1'b0}};
        op2_s = {XLEN{1'b0}};
      end
    endcase

    case (opcode_s)
      INST_TYPE_R_M, INST_TYPE_I, INST_TYPE_L,
      INST_JAL, INST_JALR, INST_LUI, INST_AUIPC: wen_base_s = 1'b1;
      default:                                   wen_base_s = 1'b0;
    endcase
    wen_s = wen_base_s && (rd_s != {REG_AW{1'b0}}) && !illegal_s;
  end

  assign stall_s    = stall1_s || stall2_s;
  assign adv_s      = !out_valid_q || out_ready_i;
  assign in_ready_o = flush_i || (adv_s && !stall_s);

  // Output register next-state: flush kills, advance loads or bubbles, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    illegal_d   = illegal_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (adv_s) begin
      if (in_valid_i && !stall_s) begin
        out_valid_d = 1'b1;
        inst_d      = inst_i;
        inst_addr_d = inst_addr_i;
        op1_d       = op1_s;
        op2_d       = op2_s;
        imm_d       = imm_s;
        rd_d        = rd_s;
        wen_d       = wen_s;
        illegal_d   = illegal_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      inst_q      <= 32'h0000_0000;
      inst_addr_q <= {XLEN{1'b0}};
      op1_q       <= {XLEN{1'b0}};
      op2_q       <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      rd_q        <= {REG_AW{1'b0}};
      wen_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign imm_o       = imm_q;
  assign rd_addr_o   = rd_q;
  assign reg_wen_o   = wen_q;
  assign illegal_o   = illegal_q;

endmodule
